// File: rtl/prot_seq_pkg.sv
// Shared definitions for the input-protection relay sequencer.
//   seq_state_e : sequencer state encoding (also exported on seq_state for debug)
//   cause_t     : latched trip cause (overvoltage / undervoltage)
//   DEF_*       : default tick constants, in LF-oscillator ticks (~108 Hz)
package prot_seq_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_ARMING  = 3'd1,
        ST_CLOSED  = 3'd2,
        ST_TRIPPED = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_LOCKOUT = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic vhi;
        logic vlo;
    } cause_t;

    localparam int DEF_ARM_TICKS     = 16;
    localparam int DEF_HOLDOFF_TICKS = 108;
    localparam int DEF_STABLE_TICKS  = 216;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_BLINK_DIV     = 27;
    localparam int DEF_CNT_WIDTH     = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
//   clk, rst_n : destination clock, async active-low reset (outputs reset to 0)
//   d          : asynchronous input
//   q          : synchronised output, two clk of latency
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/prot_relay_sequencer.sv
// Input-protection relay sequencer. Consumes the window-comparator flags,
// applies arming delay, trip latching, timed auto-retry and lockout, and
// drives the relay plus status LEDs. One tick = one clk cycle.
//   clk, rst_n        : LF clock, async active-low reset
//   por_done          : POR complete; held in POWERUP while low
//   vin_too_high      : async, 1 = overvoltage
//   vin_not_negative  : async, 0 = undervoltage
//   clear_lockout     : async level, rising edge leaves LOCKOUT
//   prot_relay_en     : 1 = relay closed
//   ok_led_en         : follows the relay
//   fault_led_en      : on in TRIPPED/HOLDOFF, blinking in LOCKOUT
//   vhi_led_en/vlo_led_en : latched cause of the last trip
//   seq_state         : current state (debug)
module prot_relay_sequencer
    import prot_seq_pkg::*;
#(
    parameter int ARM_TICKS     = DEF_ARM_TICKS,
    parameter int HOLDOFF_TICKS = DEF_HOLDOFF_TICKS,
    parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int BLINK_DIV     = DEF_BLINK_DIV,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       por_done,
    input  logic       vin_too_high,
    input  logic       vin_not_negative,
    input  logic       clear_lockout,
    output logic       prot_relay_en,
    output logic       ok_led_en,
    output logic       fault_led_en,
    output logic       vhi_led_en,
    output logic       vlo_led_en,
    output logic [2:0] seq_state
);

    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_WIDTH-1:0] ARM_LAST    = CNT_WIDTH'(ARM_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLDOFF_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] BLINK_LAST  = CNT_WIDTH'(BLINK_DIV - 1);
    localparam logic [RW-1:0]        RETRY_MAX   = RW'(MAX_RETRIES);

    // ---- input synchronisers: [0]=too_high, [1]=not_negative, [2]=clear ----
    logic [2:0] raw_in;
    logic [2:0] sync_in;

    assign raw_in = {clear_lockout, vin_not_negative, vin_too_high};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        sync_2ff #(.W(1)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (raw_in[i]),
            .q    (sync_in[i])
        );
    end

    logic hi_s, nn_s, clr_s, clr_q, clr_edge, fault;

    assign hi_s     = sync_in[0];
    assign nn_s     = sync_in[1];
    assign clr_s    = sync_in[2];
    assign clr_edge = clr_s & ~clr_q;
    assign fault    = hi_s | ~nn_s;

    // ---- state ----
    seq_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d, timer_inc;
    logic [RW-1:0]        retry_q, retry_d, retry_inc;
    cause_t               cause_q, cause_d;
    logic                 blink_d, fault_led_d, relay_d;

    assign timer_inc = timer_q + CNT_WIDTH'(1);
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        cause_d = cause_q;
        blink_d = fault_led_en;

        if (!por_done) begin
            state_d = ST_POWERUP;
        end else begin
            unique case (state_q)
                ST_POWERUP: state_d = ST_ARMING;
                ST_ARMING: begin
                    if (fault)                    timer_d = '0;
                    else if (timer_q == ARM_LAST) state_d = ST_CLOSED;
                    else                          timer_d = timer_inc;
                end
                ST_CLOSED: begin
                    if (fault) begin
                        // Capture the cause on the same update that opens the
                        // relay; a short glitch may be gone one tick later.
                        state_d = ST_TRIPPED;
                        cause_d = '{vhi: hi_s, vlo: ~nn_s};
                    end else if (timer_q == STABLE_LAST) begin
                        retry_d = '0;             // timer parks here
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_TRIPPED: begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? ST_LOCKOUT : ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (timer_q == HOLD_LAST) state_d = ST_ARMING;
                    else                      timer_d = timer_inc;
                end
                ST_LOCKOUT: begin
                    if (clr_edge) begin
                        state_d = ST_ARMING;
                        retry_d = '0;
                        cause_d = '0;
                    end else if (timer_q == BLINK_LAST) begin
                        // timer doubles as the blink divider while locked out
                        timer_d = '0;
                        blink_d = ~fault_led_en;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: state_d = ST_POWERUP;
            endcase
        end

        if (state_d == ST_CLOSED && state_q != ST_CLOSED) cause_d = '0;
        if (state_d != state_q)                           timer_d = '0;

        unique case (state_d)
            ST_TRIPPED, ST_HOLDOFF: fault_led_d = 1'b1;
            ST_LOCKOUT:             fault_led_d = (state_q == ST_LOCKOUT) ? blink_d : 1'b1;
            default:                fault_led_d = 1'b0;
        endcase

        // Closes one tick after entering CLOSED, opens on the same update
        // that leaves it (fault or por_done loss).
        relay_d = (state_q == ST_CLOSED) && (state_d == ST_CLOSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_POWERUP;
            timer_q       <= '0;
            retry_q       <= '0;
            cause_q       <= '0;
            clr_q         <= 1'b0;
            prot_relay_en <= 1'b0;
            ok_led_en     <= 1'b0;
            fault_led_en  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            cause_q       <= cause_d;
            clr_q         <= clr_s;
            prot_relay_en <= relay_d;
            ok_led_en     <= relay_d;
            fault_led_en  <= fault_led_d;
        end
    end

    assign vhi_led_en = cause_q.vhi;
    assign vlo_led_en = cause_q.vlo;
    assign seq_state  = state_q;

endmodule
